node_driver: RTL

- Initiator side of the node start/ready protocol (ST rising edge starts a node; RD low while busy, RD high when done; RES holds the result).
- Accepts operands from an upstream valid/ready stream and drives one node's IN/ST.
- Detects completion via the RD low-then-high sequence, captures RES and presents it on a downstream valid/ready stream.
- Sits between a tree-level sequencer and each computational node.

---
 rtl/node_driver_if.sv | 28 ++
 rtl/node_driver.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/node_driver_if.sv
// Bundles the three handshakes around one node: the command stream in, the node
// start/ready/result signals, and the result stream out.
interface node_driver_if #(
    parameter int unsigned W = 16
) ();
    logic         CMD_VALID;
    logic         CMD_READY;
    logic [W-1:0] CMD_DATA;
    logic         N_ST;
    logic [W-1:0] N_IN;
    logic         N_RD;
    logic [W-1:0] N_RES;
    logic         OUT_VALID;
    logic         OUT_READY;
    logic [W-1:0] OUT_DATA;

    // master: the driver itself
    modport master (
        input  CMD_VALID, CMD_DATA, N_RD, N_RES, OUT_READY,
        output CMD_READY, N_ST, N_IN, OUT_VALID, OUT_DATA
    );

    // slave: the sequencer, node and result consumer around the driver
    modport slave (
        output CMD_VALID, CMD_DATA, N_RD, N_RES, OUT_READY,
        input  CMD_READY, N_ST, N_IN, OUT_VALID, OUT_DATA
    );
endinterface

// File: rtl/node_driver.sv
// Initiator for one node: takes an operand, pulses ST, waits for RD low-then-high, returns RES.
// Define NODE_DRIVER_TIMEOUT_EN to abort stalled operations after TMO_CYCLES and flag ERR.
module node_driver #(
    parameter int unsigned W    = 16,
    parameter int unsigned CNTW = 16
`ifdef NODE_DRIVER_TIMEOUT_EN
    ,
    parameter int unsigned TMO_CYCLES = 64
`endif
) (
    input  logic            CLK,
    input  logic            RST,
    node_driver_if.master   bus,
    output logic [CNTW-1:0] DONE_CNT,
    output logic            ERR
);

    typedef enum logic [1:0] {
        StIdle,
        StFire,
        StWaitDone,
        StHold
    } state_e;

    state_e          state_q, state_d;
    logic            n_st_q, n_st_d;
    logic [W-1:0]    n_in_q, n_in_d;
    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    out_data_q, out_data_d;
    logic [CNTW-1:0] done_cnt_q, done_cnt_d;
    logic            cmd_ready;

`ifdef NODE_DRIVER_TIMEOUT_EN
    localparam int unsigned TmoW = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TMO_CYCLES - 1);

    logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic            err_q, err_d;
`endif

    assign cmd_ready = (state_q == StIdle) && bus.N_RD && !RST;

    always_comb begin
        state_d     = state_q;
        n_st_d      = n_st_q;
        n_in_d      = n_in_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        done_cnt_d  = done_cnt_q;
`ifdef NODE_DRIVER_TIMEOUT_EN
        tmo_cnt_d   = '0;
        err_d       = err_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (bus.CMD_VALID && cmd_ready) begin
                    n_in_d  = bus.CMD_DATA;
                    n_st_d  = 1'b1;
                    state_d = StFire;
                end
            end
            // Only a low RD counts as the acknowledge; a stale high is ignored here.
            StFire: begin
                if (!bus.N_RD) begin
                    n_st_d  = 1'b0;
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (bus.N_RD) begin
                    out_data_d  = bus.N_RES;
                    out_valid_d = 1'b1;
                    done_cnt_d  = done_cnt_q + CNTW'(1);
                    state_d     = StHold;
                end
            end
            StHold: begin
                if (bus.OUT_READY) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

`ifdef NODE_DRIVER_TIMEOUT_EN
        // Counter runs only while a state persists, so it restarts on FIRE->WAIT_DONE.
        if ((state_q == StFire || state_q == StWaitDone) && state_d == state_q) begin
            if (tmo_cnt_q == TmoLast) begin
                n_st_d  = 1'b0;
                err_d   = 1'b1;
                state_d = StIdle;
            end else begin
                tmo_cnt_d = tmo_cnt_q + TmoW'(1);
            end
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            n_st_q      <= 1'b0;
            n_in_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            n_st_q      <= n_st_d;
            n_in_q      <= n_in_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            done_cnt_q  <= done_cnt_d;
        end
    end

`ifdef NODE_DRIVER_TIMEOUT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
        end
    end

    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

    assign bus.CMD_READY = cmd_ready;
    assign bus.N_ST      = n_st_q;
    assign bus.N_IN      = n_in_q;
    assign bus.OUT_VALID = out_valid_q;
    assign bus.OUT_DATA  = out_data_q;
    assign DONE_CNT      = done_cnt_q;

endmodule
